rv_vote_core: RTL and testbench

- Voting datapath core of the root-voter cell.
- Contains an iterative agreement-compare unit: for each participating dataset it counts how many participating datasets hold an identical value.
- Also contains a loadable down-counting timeout counter.
- The parent cell's FSM drives both: load/enable the counter while waiting for datasets, then enable the compare and wait for done.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/rv_timeout_counter.sv | 36 +++
 rtl/rv_vote_core.sv | 132 +++++++++++++
 tb/tb_rv_vote_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the root-voter datapath: vote-type encodings,
// compare FSM states and the participant-count lookup.
package rv_pkg;

  localparam logic [1:0] V2OO2 = 2'b00;
  localparam logic [1:0] V2OO3 = 2'b01;
  localparam logic [1:0] V4OO7 = 2'b10;
  localparam logic [1:0] V5OO9 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cmp_state_e;

  // Number of leading dataset slots (A onwards) that take part in a vote.
  function automatic logic [3:0] num_participants(input logic [1:0] vote_type);
    case (vote_type)
      V2OO2:   num_participants = 4'd2;
      V2OO3:   num_participants = 4'd3;
      V4OO7:   num_participants = 4'd7;
      default: num_participants = 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/rv_timeout_counter.sv
// Loadable down-counter that saturates at zero; expired_o flags a zero count.
module rv_timeout_counter #(
  parameter int CNT_WIDTH = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 en_i,
  output logic                 expired_o
);

  logic [CNT_WIDTH-1:0] value_q;
  logic [CNT_WIDTH-1:0] value_d;

  // Load wins over decrement; the count never wraps below zero.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (en_i && (value_q != '0)) begin
      value_d = value_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign expired_o = (value_q == '0);

endmodule

// File: rtl/rv_vote_core.sv
// Root-voter datapath: iterative agreement-count compare unit plus the
// timeout counter used by the parent FSM while collecting datasets.
module rv_vote_core
  import rv_pkg::*;
#(
  parameter int REG_DATA_WIDTH = 64,
  parameter int MAX_DATASETS   = 9,
  parameter int CNT_WIDTH      = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmp_en,
  input  logic                      cmp_clear,
  input  logic [1:0]                vote_type,
  input  logic [REG_DATA_WIDTH-1:0] set_A,
  input  logic [REG_DATA_WIDTH-1:0] set_B,
  input  logic [REG_DATA_WIDTH-1:0] set_C,
  input  logic [REG_DATA_WIDTH-1:0] set_D,
  input  logic [REG_DATA_WIDTH-1:0] set_E,
  input  logic [REG_DATA_WIDTH-1:0] set_F,
  input  logic [REG_DATA_WIDTH-1:0] set_G,
  input  logic [REG_DATA_WIDTH-1:0] set_H,
  input  logic [REG_DATA_WIDTH-1:0] set_I,
  output logic [7:0]                res_A,
  output logic [7:0]                res_B,
  output logic [7:0]                res_C,
  output logic [7:0]                res_D,
  output logic [7:0]                res_E,
  output logic [7:0]                res_F,
  output logic [7:0]                res_G,
  output logic [7:0]                res_H,
  output logic [7:0]                res_I,
  output logic                      cmp_done,
  input  logic                      cnt_load,
  input  logic [CNT_WIDTH-1:0]      cnt_d,
  input  logic                      cnt_en,
  output logic                      cnt_expired
);

  logic [REG_DATA_WIDTH-1:0] set_w [MAX_DATASETS];
  logic [7:0]                res_q [MAX_DATASETS];
  cmp_state_e                state_q;
  logic [3:0]                idx_q;
  logic [3:0]                n_q;
  logic                      done_q;
  logic [7:0]                match_cnt;

  assign set_w[0] = set_A;
  assign set_w[1] = set_B;
  assign set_w[2] = set_C;
  assign set_w[3] = set_D;
  assign set_w[4] = set_E;
  assign set_w[5] = set_F;
  assign set_w[6] = set_G;
  assign set_w[7] = set_H;
  assign set_w[8] = set_I;

  // Agreement count for the slot under test, itself included.
  always_comb begin
    match_cnt = '0;
    for (int j = 0; j < MAX_DATASETS; j++) begin
      if ((4'(j) < n_q) && (set_w[j] == set_w[idx_q])) begin
        match_cnt = match_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < MAX_DATASETS; k++) res_q[k] <= '0;
    end else if (cmp_clear) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < MAX_DATASETS; k++) res_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmp_en) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            n_q     <= num_participants(vote_type);
          end
        end
        ST_RUN: begin
          if (cmp_en) begin
            res_q[idx_q] <= match_cnt;
            idx_q        <= idx_q + 4'd1;
            if (idx_q == (n_q - 4'd1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign res_A    = res_q[0];
  assign res_B    = res_q[1];
  assign res_C    = res_q[2];
  assign res_D    = res_q[3];
  assign res_E    = res_q[4];
  assign res_F    = res_q[5];
  assign res_G    = res_q[6];
  assign res_H    = res_q[7];
  assign res_I    = res_q[8];
  assign cmp_done = done_q;

  rv_timeout_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_d),
    .en_i       (cnt_en),
    .expired_o  (cnt_expired)
  );

endmodule

// File: tb/tb_rv_vote_core.sv
// Self-checking bench for rv_vote_core: directed and randomized votes and
// counter activity compared against a behavioural reference model.
module tb_rv_vote_core;

  localparam int DW = 64;
  localparam int CW = 30;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          cmp_en    = 1'b0;
  logic          cmp_clear = 1'b0;
  logic [1:0]    vote_type = 2'b00;
  logic          cnt_load  = 1'b0;
  logic          cnt_en    = 1'b0;
  logic [CW-1:0] cnt_d     = '0;
  logic [DW-1:0] sets [9];

  wire [7:0] res_A, res_B, res_C, res_D, res_E, res_F, res_G, res_H, res_I;
  wire       cmp_done;
  wire       cnt_expired;
  logic [7:0] res_w [9];

  int n_checks  = 0;
  int n_pass    = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  always_comb begin
    res_w[0] = res_A; res_w[1] = res_B; res_w[2] = res_C;
    res_w[3] = res_D; res_w[4] = res_E; res_w[5] = res_F;
    res_w[6] = res_G; res_w[7] = res_H; res_w[8] = res_I;
  end

  rv_vote_core #(
    .REG_DATA_WIDTH (DW),
    .MAX_DATASETS   (9),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmp_en      (cmp_en),
    .cmp_clear   (cmp_clear),
    .vote_type   (vote_type),
    .set_A       (sets[0]),
    .set_B       (sets[1]),
    .set_C       (sets[2]),
    .set_D       (sets[3]),
    .set_E       (sets[4]),
    .set_F       (sets[5]),
    .set_G       (sets[6]),
    .set_H       (sets[7]),
    .set_I       (sets[8]),
    .res_A       (res_A),
    .res_B       (res_B),
    .res_C       (res_C),
    .res_D       (res_D),
    .res_E       (res_E),
    .res_F       (res_F),
    .res_G       (res_G),
    .res_H       (res_H),
    .res_I       (res_I),
    .cmp_done    (cmp_done),
    .cnt_load    (cnt_load),
    .cnt_d       (cnt_d),
    .cnt_en      (cnt_en),
    .cnt_expired (cnt_expired)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int n_of(input logic [1:0] vt);
    case (vt)
      2'b00:   return 2;
      2'b01:   return 3;
      2'b10:   return 7;
      default: return 9;
    endcase
  endfunction

  // Reference: how many of the first n datasets equal dataset k (0 if k is not voting).
  function automatic int exp_res(input int k, input int n);
    int c = 0;
    if (k >= n) return 0;
    for (int j = 0; j < n; j++) if (sets[j] == sets[k]) c++;
    return c;
  endfunction

  task automatic check_all_res(input string tag, input int n);
    for (int k = 0; k < 9; k++)
      check_eq($sformatf("%s res[%0d]", tag, k), 64'(res_w[k]), 64'(exp_res(k, n)));
  endtask

  task automatic run_vote(input logic [1:0] vt, input int pause_at, input int pause_len,
                          input string tag);
    int n     = n_of(vt);
    int edges = 0;
    bit done  = 1'b0;
    @(negedge clk);
    vote_type = vt;
    cmp_en    = 1'b1;
    while (!done && edges < 64) begin
      @(posedge clk);
      edges++;
      #1;
      if (cmp_done) begin
        done = 1'b1;
      end else begin
        if (edges == 1) vote_type = ~vt;
        if (pause_len > 0 && edges == pause_at) cmp_en = 1'b0;
        if (pause_len > 0 && edges == pause_at + pause_len) cmp_en = 1'b1;
      end
    end
    check_eq({tag, " latency"}, 64'(edges), 64'(n + 1 + pause_len));
    check_all_res(tag, n);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq({tag, " done hold"}, 64'(cmp_done), 64'd1);
    check_eq({tag, " res hold"}, 64'(res_w[0]), 64'(exp_res(0, n)));
    cmp_en    = 1'b0;
    cmp_clear = 1'b1;
    @(posedge clk);
    #1;
    cmp_clear = 1'b0;
    check_eq({tag, " clear done"}, 64'(cmp_done), 64'd0);
    check_all_res({tag, " clr"}, 0);
  endtask

  task automatic cnt_step(input bit ld, input int d, input bit en);
    cnt_load = ld;
    cnt_d    = CW'(d);
    cnt_en   = en;
    @(posedge clk);
    if (ld) cnt_model = d;
    else if (en && cnt_model > 0) cnt_model--;
    #1;
    check_eq("cnt_expired", 64'(cnt_expired), 64'(cnt_model == 0));
  endtask

  initial begin
    logic [DW-1:0] pool [3];
    logic [1:0]    vt;
    int            n;
    int            p_at;
    int            p_len;

    for (int k = 0; k < 9; k++) sets[k] = '0;

    #2 reset = 1'b0;
    #1;
    check_all_res("reset", 0);
    check_eq("reset done", 64'(cmp_done), 64'd0);
    check_eq("reset expired", 64'(cnt_expired), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 9; k++) sets[k] = (k < 3) ? 64'h55 : 64'h0;
    run_vote(2'b01, 0, 0, "2oo3 eq");

    for (int k = 0; k < 9; k++) sets[k] = (k < 5) ? 64'h1 : (k < 8) ? 64'h2 : 64'h3;
    run_vote(2'b11, 0, 0, "5oo9 mix");

    for (int k = 0; k < 9; k++) sets[k] = '0;
    sets[0] = 64'h1;
    sets[1] = 64'h2;
    run_vote(2'b00, 2, 3, "2oo2 pause");

    sets[0] = 64'h8000_0000_0000_0000;
    sets[1] = 64'h0;
    run_vote(2'b00, 0, 0, "2oo2 msb");

    repeat (12) begin
      for (int p = 0; p < 3; p++) pool[p] = {$urandom, $urandom};
      for (int k = 0; k < 9; k++) begin
        sets[k] = pool[$urandom_range(0, 2)];
        if ($urandom_range(0, 5) == 0) sets[k] = sets[k] ^ (64'd1 << $urandom_range(0, 63));
      end
      vt    = 2'($urandom_range(0, 3));
      n     = n_of(vt);
      p_len = 0;
      p_at  = 0;
      if ($urandom_range(0, 1) == 1) begin
        p_at  = $urandom_range(1, n);
        p_len = $urandom_range(1, 3);
      end
      run_vote(vt, p_at, p_len, "rand");
    end

    cnt_step(1'b1, 5, 1'b0);
    repeat (7) cnt_step(1'b0, 0, 1'b1);
    cnt_step(1'b1, 4, 1'b1);
    repeat (2) cnt_step(1'b0, 0, 1'b1);
    cnt_step(1'b1, 0, 1'b0);
    repeat (30) cnt_step($urandom_range(0, 7) == 0, $urandom_range(0, 6), 1'($urandom_range(0, 1)));

    cnt_step(1'b1, 20, 1'b0);
    cnt_load = 1'b0;
    for (int k = 0; k < 9; k++) sets[k] = 64'($urandom_range(0, 1));
    @(negedge clk);
    vote_type = 2'b10;
    cmp_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrun res[0]", 64'(res_w[0]), 64'(exp_res(0, 7)));
    check_eq("midrun res[1]", 64'(res_w[1]), 64'(exp_res(1, 7)));
    #2 reset = 1'b0;
    #1;
    check_all_res("async rst", 0);
    check_eq("async rst done", 64'(cmp_done), 64'd0);
    check_eq("async rst expired", 64'(cnt_expired), 64'd1);
    cmp_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post rst done", 64'(cmp_done), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
